// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-alarm timekeeping core.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
package clock_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int MIN_PER_HOUR  = 60;
  localparam int SEC_PER_MIN   = 60;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
  } hhmm_t;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == 6'(MIN_PER_HOUR - 1)) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [23:0] to_decimal(input logic [4:0] h,
                                             input logic [5:0] m,
                                             input logic [5:0] s);
    return 24'(h) * 24'd10000 + 24'(m) * 24'd100 + 24'(s);
  endfunction

  // 0 shows as 12 and afternoon hours fold back to 1..11
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0) begin
      return 5'd12;
    end else if (h > 5'd12) begin
      return h - 5'd12;
    end else begin
      return h;
    end
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: hh:mm setting, IDLE/RINGING/SNOOZED FSM and ring timer.
// Snooze state and target exist only when ALARM_SNOOZE_EN is defined.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  logic  adj_minutes,
  input  logic  adj_hours,
  input  logic  tick,
  input  logic  new_minute,
  input  hhmm_t cur_time,
  input  logic  snooze,
  input  logic  dismiss,
  output hhmm_t setting,
  output logic  ringing
);

  localparam int RW = (RING_SEC > 2) ? $clog2(RING_SEC) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

  alarm_state_t  state_reg;
  hhmm_t         setting_reg;
  logic [RW-1:0] ring_cnt_reg;
  logic          ringing_reg;
  logic          alarm_hit;

  assign alarm_hit = new_minute && (cur_time == setting_reg);
  assign setting   = setting_reg;
  assign ringing   = ringing_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setting_reg <= '0;
    end else begin
      if (adj_minutes) begin
        setting_reg.minutes <= inc_mod60(setting_reg.minutes);
      end
      if (adj_hours) begin
        setting_reg.hours <= inc_mod24(setting_reg.hours);
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  hhmm_t      snooze_target_reg;
  hhmm_t      snooze_target_next;
  logic [6:0] snooze_min_sum;
  logic       snooze_hit;

  assign snooze_min_sum = {1'b0, cur_time.minutes} + 7'(SNOOZE_MIN);
  assign snooze_hit     = new_minute && (cur_time == snooze_target_reg);

  // Minutes overflow carries into the hour, which itself wraps past midnight
  always_comb begin
    snooze_target_next = cur_time;
    if (snooze_min_sum >= 7'(MIN_PER_HOUR)) begin
      snooze_target_next.minutes = 6'(snooze_min_sum - 7'(MIN_PER_HOUR));
      snooze_target_next.hours   = inc_mod24(cur_time.hours);
    end else begin
      snooze_target_next.minutes = snooze_min_sum[5:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snooze_target_reg <= '0;
    end else if (enable && state_reg == RINGING && snooze && !dismiss) begin
      snooze_target_reg <= snooze_target_next;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = snooze ^ SNOOZE_MIN[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ringing_reg  <= 1'b0;
      ring_cnt_reg <= '0;
    end else if (!enable) begin
      state_reg   <= IDLE;
      ringing_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (alarm_hit) begin
            state_reg    <= RINGING;
            ringing_reg  <= 1'b1;
            ring_cnt_reg <= '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_reg   <= IDLE;
            ringing_reg <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_reg   <= SNOOZED;
            ringing_reg <= 1'b0;
`endif
          end else if (tick) begin
            if (ring_cnt_reg == RING_LAST) begin
              state_reg   <= IDLE;
              ringing_reg <= 1'b0;
            end else begin
              ring_cnt_reg <= ring_cnt_reg + RW'(1);
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZED: begin
          if (dismiss) begin
            state_reg <= IDLE;
          end else if (snooze_hit) begin
            state_reg    <= RINGING;
            ringing_reg  <= 1'b1;
            ring_cnt_reg <= '0;
          end
        end
`endif
        default: begin
          state_reg   <= IDLE;
          ringing_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour hh:mm:ss timekeeper with N_ALARMS alarm channels and a registered display number.
// Define ALARM_SNOOZE_EN to build the snooze feature into every channel.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int N_ALARMS   = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adj_minutes,
  input  logic                adj_hours,
  input  logic [2:0]          sel,
  input  logic                fmt_12h,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [23:0]         number,
  output logic                pm,
  output logic [N_ALARMS-1:0] ringing,
  output logic                any_ringing
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0]       pre_cnt_reg;
  logic [4:0]          hours_reg;
  logic [5:0]          minutes_reg;
  logic [5:0]          seconds_reg;
  logic                time_upd_reg;
  logic [23:0]         number_reg;
  logic                pm_reg;
  logic [2:0]          sel_eff;
  logic                tick;
  logic                time_adj;
  logic                new_minute;
  hhmm_t               cur_time;
  hhmm_t               ch_setting [N_ALARMS];
  logic [N_ALARMS-1:0] ring_vec;
  logic [4:0]          disp_hours;
  logic [5:0]          disp_minutes;
  logic [5:0]          disp_seconds;
  logic [4:0]          disp_hours_fmt;

  // Out-of-range selections fall back to the time of day
  assign sel_eff    = (sel > 3'(N_ALARMS)) ? 3'd0 : sel;
  assign tick       = (pre_cnt_reg == PRE_LAST);
  assign time_adj   = (sel_eff == 3'd0) && (adj_minutes || adj_hours);
  assign new_minute = time_upd_reg && (seconds_reg == 6'd0);
  assign cur_time   = '{hours: hours_reg, minutes: minutes_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_reg <= '0;
    end else if (time_adj || tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PW'(1);
    end
  end

  // An adjust on the time target takes precedence and swallows a coincident tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hours_reg    <= '0;
      minutes_reg  <= '0;
      seconds_reg  <= '0;
      time_upd_reg <= 1'b0;
    end else begin
      time_upd_reg <= time_adj || tick;
      if (time_adj) begin
        if (adj_minutes) begin
          minutes_reg <= inc_mod60(minutes_reg);
        end
        if (adj_hours) begin
          hours_reg <= inc_mod24(hours_reg);
        end
        seconds_reg <= '0;
      end else if (tick) begin
        seconds_reg <= inc_mod60(seconds_reg);
        if (seconds_reg == 6'(SEC_PER_MIN - 1)) begin
          minutes_reg <= inc_mod60(minutes_reg);
          if (minutes_reg == 6'(MIN_PER_HOUR - 1)) begin
            hours_reg <= inc_mod24(hours_reg);
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
    logic ch_sel;
    assign ch_sel = (sel_eff == 3'(gi + 1));

    alarm_channel #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_MIN(SNOOZE_MIN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable     (alarm_en[gi]),
      .adj_minutes(adj_minutes && ch_sel),
      .adj_hours  (adj_hours && ch_sel),
      .tick       (tick),
      .new_minute (new_minute),
      .cur_time   (cur_time),
      .snooze     (snooze),
      .dismiss    (dismiss),
      .setting    (ch_setting[gi]),
      .ringing    (ring_vec[gi])
    );
  end

  always_comb begin
    disp_hours   = hours_reg;
    disp_minutes = minutes_reg;
    disp_seconds = seconds_reg;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (sel_eff == 3'(k + 1)) begin
        disp_hours   = ch_setting[k].hours;
        disp_minutes = ch_setting[k].minutes;
        disp_seconds = 6'd0;
      end
    end
  end

  assign disp_hours_fmt = fmt_12h ? to_12h(disp_hours) : disp_hours;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number_reg <= '0;
      pm_reg     <= 1'b0;
    end else begin
      number_reg <= to_decimal(disp_hours_fmt, disp_minutes, disp_seconds);
      pm_reg     <= (disp_hours >= 5'd12);
    end
  end

  assign number      = number_reg;
  assign pm          = pm_reg;
  assign ringing     = ring_vec;
  assign any_ringing = |ring_vec;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: tasks push expected outputs, a negedge monitor compares.
// Snooze scenarios follow whichever ALARM_SNOOZE_EN build is under test.
module tb_multi_alarm_clock;

  localparam int CLK_FREQ   = 10;
  localparam int N_ALARMS   = 2;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_MIN = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adj_minutes = 1'b0;
  logic        adj_hours = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        fmt_12h = 1'b0;
  logic [1:0]  alarm_en = 2'b00;
  logic        snooze = 1'b0;
  logic        dismiss = 1'b0;
  logic [23:0] number;
  logic        pm;
  logic [1:0]  ringing;
  logic        any_ringing;

  multi_alarm_clock #(
    .CLK_FREQ  (CLK_FREQ),
    .N_ALARMS  (N_ALARMS),
    .RING_SEC  (RING_SEC),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adj_minutes(adj_minutes),
    .adj_hours  (adj_hours),
    .sel        (sel),
    .fmt_12h    (fmt_12h),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .number     (number),
    .pm         (pm),
    .ringing    (ringing),
    .any_ringing(any_ringing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_NUM, K_PM, K_RING, K_ANY} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [23:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Time-of-day model: tracks where the clock is so tasks know when events land
  int mh = 0, mm = 0, ms = 0, mpc = 0;
  int ah[N_ALARMS];
  int am[N_ALARMS];

  function automatic void push_exp(input string name, input kind_t kind, input logic [23:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    e.due  = cyc;
    sb.push_back(e);
  endfunction

  exp_t        mon_e;
  logic [23:0] mon_obs;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_NUM:   mon_obs = number;
        K_PM:    mon_obs = {23'd0, pm};
        K_RING:  mon_obs = {22'd0, ringing};
        default: mon_obs = {23'd0, any_ringing};
      endcase
      n_cmp++;
      if (mon_obs !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", mon_e.name, mon_obs, mon_e.val, cyc);
      end else begin
        $display("ok   %s = %0d (cycle %0d)", mon_e.name, mon_obs, cyc);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) begin
        mh = 0; mm = 0; ms = 0; mpc = 0;
        for (int k = 0; k < N_ALARMS; k++) begin
          ah[k] = 0;
          am[k] = 0;
        end
      end else begin
        int se;
        se = (int'(sel) > N_ALARMS) ? 0 : int'(sel);
        if (se == 0 && (adj_minutes || adj_hours)) begin
          if (adj_minutes) mm = (mm + 1) % 60;
          if (adj_hours) mh = (mh + 1) % 24;
          ms = 0;
          mpc = 0;
        end else if (mpc == CLK_FREQ - 1) begin
          mpc = 0;
          ms = ms + 1;
          if (ms == 60) begin
            ms = 0;
            mm = mm + 1;
            if (mm == 60) begin
              mm = 0;
              mh = (mh + 1) % 24;
            end
          end
        end else begin
          mpc = mpc + 1;
        end
        if (se != 0) begin
          if (adj_minutes) am[se-1] = (am[se-1] + 1) % 60;
          if (adj_hours) ah[se-1] = (ah[se-1] + 1) % 24;
        end
      end
      #1;
    end
  endtask

  task automatic pulse(input bit m, input bit h, input bit s, input bit d);
    adj_minutes = m;
    adj_hours   = h;
    snooze      = s;
    dismiss     = d;
    step(1);
    adj_minutes = 1'b0;
    adj_hours   = 1'b0;
    snooze      = 1'b0;
    dismiss     = 1'b0;
  endtask

  task automatic run_until(input int h, input int m, input int s);
    int guard;
    guard = 0;
    while (!(mh == h && mm == m && ms == s) && guard < 5000) begin
      step(1);
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_until timeout: got %0d:%0d:%0d expected %0d:%0d:%0d", mh, mm, ms, h, m, s);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    sel = 3'd0;
    do pulse(1'b1, 1'b0, 1'b0, 1'b0); while (mm != m);
    while (mh != h) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(h, m, s);
  endtask

  task automatic set_alarm(input int k, input int h, input int m);
    sel = 3'(k + 1);
    while (am[k] != m) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    while (ah[k] != h) pulse(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    n_cmp++;
    if (number !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_number: got %0d expected 0", number);
    end
    n_cmp++;
    if (pm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pm: got %0d expected 0", pm);
    end
    n_cmp++;
    if (ringing !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ringing: got %0d expected 0", ringing);
    end
    n_cmp++;
    if (any_ringing !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_any: got %0d expected 0", any_ringing);
    end
    rst = 1'b0;
    step(CLK_FREQ);
    push_exp("first_tick_pre", K_NUM, 24'd0);
    step(1);
    push_exp("first_tick", K_NUM, 24'd1);
    set_time(23, 59, 59);
    step(1);
    push_exp("day_last", K_NUM, 24'd235959);
    push_exp("day_last_pm", K_PM, 24'd1);
    run_until(0, 0, 0);
    step(1);
    push_exp("day_wrap", K_NUM, 24'd0);
    push_exp("day_wrap_pm", K_PM, 24'd0);
  endtask

  task automatic test_12h;
    fmt_12h = 1'b1;
    set_time(12, 59, 30);
    step(1);
    push_exp("fmt12_noon", K_NUM, 24'd125930);
    push_exp("fmt12_noon_pm", K_PM, 24'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    push_exp("fmt12_adj_hour", K_NUM, 24'd15900);
    push_exp("fmt12_adj_hour_pm", K_PM, 24'd1);
    set_time(0, 10, 0);
    step(1);
    push_exp("fmt12_midnight", K_NUM, 24'd121000);
    push_exp("fmt12_midnight_pm", K_PM, 24'd0);
    fmt_12h = 1'b0;
    step(1);
    push_exp("fmt24_midnight", K_NUM, 24'd1000);
    sel = 3'd3;
    step(1);
    push_exp("sel_out_of_range", K_NUM, 24'd1000);
    sel = 3'd0;
  endtask

  task automatic test_alarm;
    set_alarm(0, 7, 30);
    step(1);
    push_exp("alarm0_display", K_NUM, 24'd73000);
    sel = 3'd0;
    alarm_en = 2'b01;
    set_time(7, 29, 59);
    run_until(7, 30, 0);
    push_exp("alarm0_match_cycle", K_RING, 24'd0);
    step(1);
    push_exp("alarm0_rings", K_RING, 24'd1);
    push_exp("alarm0_any", K_ANY, 24'd1);
    run_until(7, 30, 2);
    push_exp("alarm0_still_ringing", K_RING, 24'd1);
    run_until(7, 30, 3);
    push_exp("alarm0_timeout", K_RING, 24'd0);
    push_exp("alarm0_timeout_any", K_ANY, 24'd0);
  endtask

  task automatic test_snooze;
    set_alarm(0, 23, 58);
    set_time(23, 57, 59);
    run_until(23, 58, 0);
    step(1);
    push_exp("snooze_rings", K_RING, 24'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef ALARM_SNOOZE_EN
    push_exp("snooze_silences", K_RING, 24'd0);
    run_until(0, 3, 0);
    push_exp("snooze_target_cycle", K_RING, 24'd0);
    step(1);
    push_exp("snooze_rerings", K_RING, 24'd1);
`else
    push_exp("snooze_ignored", K_RING, 24'd1);
    run_until(0, 3, 0);
    push_exp("snooze_off_idle", K_RING, 24'd0);
    step(1);
    push_exp("snooze_off_no_rering", K_RING, 24'd0);
`endif
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    push_exp("snooze_dismissed", K_RING, 24'd0);
  endtask

  task automatic test_back_to_back;
    set_alarm(0, 8, 0);
    set_alarm(1, 8, 0);
    sel = 3'd0;
    alarm_en = 2'b11;
    set_time(7, 59, 59);
    run_until(8, 0, 0);
    step(1);
    push_exp("both_ring", K_RING, 24'd3);
    push_exp("both_any", K_ANY, 24'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    push_exp("dismiss_beats_snooze", K_RING, 24'd0);
    push_exp("dismiss_any", K_ANY, 24'd0);
  endtask

  task automatic test_enable_and_adjust;
    set_time(7, 59, 59);
    run_until(8, 0, 0);
    step(1);
    push_exp("en_ring_both", K_RING, 24'd3);
    alarm_en = 2'b10;
    step(1);
    push_exp("en_drop_ch0", K_RING, 24'd2);
    alarm_en = 2'b00;
    step(1);
    push_exp("en_drop_all", K_RING, 24'd0);
    set_time(10, 20, 45);
    step(CLK_FREQ - 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    push_exp("adj_beats_tick", K_NUM, 24'd102100);
    step(CLK_FREQ - 2);
    push_exp("tick_dropped_hold", K_NUM, 24'd102100);
    step(2);
    push_exp("tick_after_adj", K_NUM, 24'd102101);
  endtask

  initial begin
    test_reset;
    test_12h;
    test_alarm;
    test_snooze;
    test_back_to_back;
    test_enable_and_adjust;
    step(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
